nios2_cpu_mul_iter: RTL and testbench
=====================================

// Module: nios2_cpu_mul_iter
// PURPOSE
//  Parametrised iterative multiplier for the Nios II ALU (A-stage); one SLICE_W x SLICE_W
//  DSP multiplier is reused over (DATA_W/SLICE_W)^2 cycles to build the full 2*DATA_W
//  product. Supports low-word MUL and high-word MULXSS/MULXSU/MULXUU.
//  Start/busy/done handshake with abort; the pipeline stalls on busy.
// PARAMETERS
//  DATA_W   32  operand/result width; must be a multiple of SLICE_W
//  SLICE_W  16  DSP slice width; NPP = (DATA_W/SLICE_W)^2 partial products (4 at defaults)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  mul_start    in   1       request; accepted only in IDLE or DONE
//  mul_kill     in   1       abort in-flight op (pipeline flush)
//  mul_mode     in   2       00 MUL(low), 01 MULXSS, 10 MULXSU(src1 s, src2 u), 11 MULXUU
//  mul_src1     in   DATA_W  multiplicand
//  mul_src2     in   DATA_W  multiplier
//  mul_busy     out  1       high while in CALC
//  mul_done     out  1       one-cycle pulse; mul_result valid
//  mul_result   out  DATA_W  low or high word per mode; held until next done
// BEHAVIOUR
//  Reset: state=IDLE; mul_busy=0, mul_done=0, mul_result=0, accumulator=0, index=0.
//  States: IDLE -(start)-> CALC -(idx==NPP-1)-> DONE -(start)-> CALC; DONE -(!start)-> IDLE.
//  Accept edge E0: latch mode and operand magnitudes. Signed operands (per mode) are
//   converted to |x| as DATA_W-bit unsigned; 0x8000_0000 -> magnitude 2^31 (no overflow).
//   Latch neg = sign1 ^ sign2 (only for operands treated as signed; MUL and MULXUU: neg=0).
//   Clear accumulator (2*DATA_W bits), idx=0.
//  CALC edges E1..ENPP: pp = slice(|a|,i) * slice(|b|,j), zero-extended, shifted
//   left by (i+j)*SLICE_W and added to the accumulator; idx = i*(DATA_W/SLICE_W)+j, increments.
//  Edge E(NPP+1): state=DONE; mul_result = (neg ? -acc : acc) low half for MUL, high half
//   otherwise; mul_done=1 for exactly that cycle. Defaults: done 5 cycles after the accept edge.
//  mul_busy=1 from E0 until E(NPP+1); 0 in IDLE and DONE.
//  start while busy: ignored (no queueing). start during DONE: accepted (back-to-back).
//  kill in CALC: next edge -> IDLE, busy=0, no done, mul_result unchanged.
//   kill with start in the same cycle: kill wins, nothing accepted.
//  kill in IDLE or DONE: no effect on result; a done pulse still lasts exactly one cycle.
//  reset_n low at any time: immediate return to reset values, op lost.
//  All arithmetic is modulo 2^(2*DATA_W); MUL low word is sign-agnostic.
// STRUCTURE
//  Package nios2_mul_pkg: mode localparams (MUL_LO, MUL_XSS, MUL_XSU, MUL_XUU),
//   state enum encoding (IDLE, CALC, DONE).
//  Sub-module nios2_mul_slice: registered-free SLICE_W x SLICE_W unsigned multiply
//   (maps to one DSP block); the parent owns operand muxing, shift, accumulate, negate.
//  Elaboration check: DATA_W % SLICE_W == 0, else $error.
// TESTING
//  1 src1=0x0001_0003 src2=0x0002_0005 MUL -> 0x000B_000F; MULXUU -> 0x0000_0002;
//    done exactly 5 cycles after accept, busy high for 5 cycles.
//  2 src1=src2=0xFFFF_FFFF: MUL->0x0000_0001, XUU->0xFFFF_FFFE, XSS->0x0000_0000,
//    XSU->0xFFFF_FFFF.
//  3 src1=src2=0x8000_0000: XSS->0x4000_0000, MUL->0x0000_0000, XUU->0x4000_0000.
//  4 kill at second CALC cycle -> no done, busy=0 next cycle, result keeps prior value;
//    start held during CALC ignored.
//  5 start asserted during done cycle with new operands -> second done 5 cycles later,
//    correct value; reset_n pulsed mid-CALC -> busy/done/result = 0 asynchronously.
//  6 random signed/unsigned sweep, all modes, DATA_W=32/SLICE_W=16 and
//    DATA_W=64/SLICE_W=16 (NPP=16) vs. reference model.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II iterative multiplier: mode encodings and
// controller state encoding.
package nios2_mul_pkg;

  localparam logic [1:0] MUL_LO  = 2'b00;
  localparam logic [1:0] MUL_XSS = 2'b01;
  localparam logic [1:0] MUL_XSU = 2'b10;
  localparam logic [1:0] MUL_XUU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nios2_mul_slice.sv
// Unregistered SLICE_W x SLICE_W unsigned multiply; intended to map onto a
// single DSP block.
module nios2_mul_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0]   a_i,
  input  logic [SLICE_W-1:0]   b_i,
  output logic [2*SLICE_W-1:0] p_o
);

  assign p_o = {{SLICE_W{1'b0}}, a_i} * {{SLICE_W{1'b0}}, b_i};

endmodule

// File: rtl/nios2_cpu_mul_iter.sv
// Iterative multiplier for the Nios II ALU: one slice multiplier reused over
// (DATA_W/SLICE_W)^2 cycles, then a sign-fix cycle that publishes the result.
module nios2_cpu_mul_iter
  import nios2_mul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mul_start,
  input  logic              mul_kill,
  input  logic [1:0]        mul_mode,
  input  logic [DATA_W-1:0] mul_src1,
  input  logic [DATA_W-1:0] mul_src2,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [DATA_W-1:0] mul_result
);

  localparam int NPS   = DATA_W / SLICE_W;
  localparam int NPP   = NPS * NPS;
  localparam int ACC_W = 2 * DATA_W;
  localparam int IDX_W = $clog2(NPP + 1);
  localparam int SEL_W = (NPS > 1) ? $clog2(NPS) : 1;

  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_width
      $error("nios2_cpu_mul_iter: DATA_W must be a multiple of SLICE_W");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   i_q, i_d, j_q, j_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic               sign1, sign2;
  logic [DATA_W-1:0]  a_mag, b_mag;
  logic [SLICE_W-1:0] slice_a, slice_b;
  logic [2*SLICE_W-1:0] pp;
  logic [ACC_W-1:0]   pp_ext, acc_fin;
  int                 lsb_a, lsb_b;

  // Only the operands a mode treats as signed contribute a sign.
  assign sign1 = ((mul_mode == MUL_XSS) || (mul_mode == MUL_XSU)) && mul_src1[DATA_W-1];
  assign sign2 = (mul_mode == MUL_XSS) && mul_src2[DATA_W-1];
  assign a_mag = sign1 ? -mul_src1 : mul_src1;
  assign b_mag = sign2 ? -mul_src2 : mul_src2;

  always_comb begin
    lsb_a   = int'(i_q) * SLICE_W;
    lsb_b   = int'(j_q) * SLICE_W;
    slice_a = a_q[lsb_a +: SLICE_W];
    slice_b = b_q[lsb_b +: SLICE_W];
  end

  nios2_mul_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .p_o (pp)
  );

  assign pp_ext  = ACC_W'(pp) << ((int'(i_q) + int'(j_q)) * SLICE_W);
  assign acc_fin = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    i_d      = i_q;
    j_d      = j_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (mul_start && !mul_kill) begin
          state_d = CALC;
          mode_d  = mul_mode;
          neg_d   = sign1 ^ sign2;
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = '0;
          idx_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      CALC: begin
        if (mul_kill) begin
          state_d = IDLE;
        end else if (idx_q == IDX_W'(NPP)) begin
          // All partial products are in; apply the sign and pick the half.
          state_d  = DONE;
          result_d = (mode_q == MUL_LO) ? acc_fin[DATA_W-1:0] : acc_fin[ACC_W-1:DATA_W];
        end else begin
          acc_d = acc_q + pp_ext;
          idx_d = idx_q + IDX_W'(1);
          if (j_q == SEL_W'(NPS - 1)) begin
            j_d = '0;
            i_d = (i_q == SEL_W'(NPS - 1)) ? '0 : i_q + SEL_W'(1);
          end else begin
            j_d = j_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= MUL_LO;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      i_q      <= i_d;
      j_q      <= j_d;
      result_q <= result_d;
    end
  end

  assign mul_busy   = (state_q == CALC);
  assign mul_done   = (state_q == DONE);
  assign mul_result = result_q;

endmodule

// File: tb/tb_nios2_cpu_mul_iter.sv
// Directed and random checks of the iterative multiplier at 32/16 and 64/16,
// against hand-computed values and a sign-extend-and-multiply model.
module tb_nios2_cpu_mul_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, kill;
  logic [1:0]  mode;
  logic [31:0] src1, src2, result;
  logic        busy, done;

  logic        start_w;
  logic [1:0]  mode_w;
  logic [63:0] src1_w, src2_w, result_w;
  logic        busy_w, done_w;
  logic        kill_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios2_cpu_mul_iter #(.DATA_W(32), .SLICE_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mul_start  (start),
    .mul_kill   (kill),
    .mul_mode   (mode),
    .mul_src1   (src1),
    .mul_src2   (src2),
    .mul_busy   (busy),
    .mul_done   (done),
    .mul_result (result)
  );

  nios2_cpu_mul_iter #(.DATA_W(64), .SLICE_W(16)) dut_w (
    .clk        (clk),
    .reset_n    (reset_n),
    .mul_start  (start_w),
    .mul_kill   (kill_w),
    .mul_mode   (mode_w),
    .mul_src1   (src1_w),
    .mul_src2   (src2_w),
    .mul_busy   (busy_w),
    .mul_done   (done_w),
    .mul_result (result_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = ((m == 2'b01 || m == 2'b10) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = ((m == 2'b01) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [63:0] ref64(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = ((m == 2'b01 || m == 2'b10) && a[63]) ? {{64{1'b1}}, a} : {64'h0, a};
    eb = ((m == 2'b01) && b[63]) ? {{64{1'b1}}, b} : {64'h0, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Called at the falling edge right after the accept edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    int lat, bc;
    @(negedge clk);
    mode = m; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_busy"}, 64'(bc), 64'd5);
    chk(tag, {32'h0, result}, {32'h0, exp});
    @(negedge clk);
    chk({tag, "_pulse"}, {63'h0, done}, 64'h0);
  endtask

  task automatic op64(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp, input string tag);
    int lat;
    @(negedge clk);
    mode_w = m; src1_w = a; src2_w = b; start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    lat = 0;
    while (!done_w && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd17);
    chk(tag, result_w, exp);
  endtask

  initial begin
    int lat, bc;
    logic [31:0] ra, rb;
    logic [63:0] wa, wb;
    logic [1:0]  rm;
    logic        saw_done;

    reset_n = 1'b0; start = 1'b0; kill = 1'b0; mode = 2'b00; src1 = '0; src2 = '0;
    start_w = 1'b0; kill_w = 1'b0; mode_w = 2'b00; src1_w = '0; src2_w = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_result", {32'h0, result}, 64'h0);
    chk("rst_result_w", result_w, 64'h0);
    reset_n = 1'b1;

    op32(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "t1_mul");
    op32(2'b11, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, "t1_xuu");

    op32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "t2_mul");
    op32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "t2_xuu");
    op32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "t2_xss");
    op32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_xsu");

    op32(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "t3_xss");
    op32(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "t3_mul");
    op32(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "t3_xuu");
    op32(2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "t3_xsu_neg");
    op32(2'b01, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0001, "t3_xss_pos");

    // Kill at the second CALC cycle with start held; prior result is 0x4000_0000 high word 1 -> 0x1.
    @(negedge clk);
    mode = 2'b00; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    @(negedge clk);
    chk("t4_busy_calc", {63'h0, busy}, 64'h1);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    chk("t4_kill_busy", {63'h0, busy}, 64'h0);
    chk("t4_kill_done", {63'h0, done}, 64'h0);
    chk("t4_kill_result", {32'h0, result}, 64'h1);
    saw_done = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t4_no_done", {63'h0, saw_done}, 64'h0);
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("t4_kill_start_idle", {63'h0, busy}, 64'h0);

    // Start held through CALC while operands change: first operands must win.
    @(negedge clk);
    mode = 2'b11; src1 = 32'h0001_0003; src2 = 32'h0002_0005; start = 1'b1;
    @(negedge clk);
    src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    chk("t4_hold_nodone", {63'h0, done}, 64'h0);
    start = 1'b0;
    @(negedge clk);
    chk("t4_hold_done", {63'h0, done}, 64'h1);
    chk("t4_hold_result", {32'h0, result}, 64'h2);

    // Back-to-back start during the done cycle.
    mode = 2'b00; src1 = 32'h0001_0003; src2 = 32'h0002_0005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_b2b_busy", {63'h0, busy}, 64'h1);
    wait_done(lat, bc);
    chk("t5_b2b_lat", 64'(lat), 64'd5);
    chk("t5_b2b_result", {32'h0, result}, 64'h000B_000F);

    // Kill during the done cycle leaves the result alone.
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("t5_kill_done_pulse", {63'h0, done}, 64'h0);
    chk("t5_kill_done_result", {32'h0, result}, 64'h000B_000F);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    mode = 2'b11; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_arst_busy", {63'h0, busy}, 64'h0);
    chk("t5_arst_done", {63'h0, done}, 64'h0);
    chk("t5_arst_result", {32'h0, result}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      ra = $urandom; rb = $urandom; rm = 2'(k);
      op32(rm, ra, rb, ref32(rm, ra, rb), "t6_rnd32");
    end

    op64(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "t6_w_mul");
    op64(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, "t6_w_xuu");
    op64(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, "t6_w_xss");
    op64(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "t6_w_xsu");
    for (int k = 0; k < 8; k++) begin
      wa = {$urandom, $urandom}; wb = {$urandom, $urandom}; rm = 2'(k);
      op64(rm, wa, wb, ref64(rm, wa, wb), "t6_rnd64");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
